// File: rtl/lcd_writer_if.sv
// Command handshake between a host and the HD44780 writer: valid/ready push of {rs, data}.
interface lcd_writer_if;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic       cmd_rs_i;
  logic [7:0] cmd_data_i;

  modport master (output cmd_valid_i, output cmd_rs_i, output cmd_data_i, input cmd_ready_o);
  modport slave  (input cmd_valid_i, input cmd_rs_i, input cmd_data_i, output cmd_ready_o);
endinterface

// File: rtl/lcd_writer.sv
// HD44780 write-only driver: small command FIFO feeding a SETUP/PULSE/HOLD/WAIT bus sequencer.
module lcd_writer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYC    = 2,
  parameter int EN_CYC       = 12,
  parameter int HOLD_CYC     = 2,
  parameter int WAIT_CYC     = 2000,
  parameter int CLR_WAIT_CYC = 80000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  lcd_writer_if.slave  cmd,
  output logic         busy_o,
  output logic         lcd_on_o,
  output logic         lcd_en_o,
  output logic         lcd_rs_o,
  output logic         lcd_rw_o,
  output logic [7:0]   lcd_data_o
);
  localparam int AW  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int M0  = (CLR_WAIT_CYC > EN_CYC) ? CLR_WAIT_CYC : EN_CYC;
  localparam int M1  = (M0 > WAIT_CYC) ? M0 : WAIT_CYC;
  localparam int M2  = (M1 > SETUP_CYC) ? M1 : SETUP_CYC;
  localparam int CNT_MAX = (M2 > HOLD_CYC) ? M2 : HOLD_CYC;
  localparam int CW  = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_EN    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_WAIT  = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0] LD_CLR   = CW'(CLR_WAIT_CYC - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT} state_t;

  cmd_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  state_t        state;
  logic [CW-1:0] cnt;
  cmd_t          head;
  logic          push, pop, wait_done, go_idle, is_clr;

  assign head      = mem[rd_ptr];
  assign push      = cmd.cmd_valid_i & cmd.cmd_ready_o;
  assign wait_done = (state == S_WAIT) && (cnt == '0);
  // The FIFO only ever feeds the sequencer from IDLE or straight out of a finished WAIT.
  assign pop       = (count != '0) && ((state == S_IDLE) || wait_done);
  assign go_idle   = !pop && ((state == S_IDLE) || wait_done);
  assign is_clr    = !lcd_rs_o && ((lcd_data_o == 8'h01) || (lcd_data_o == 8'h02) ||
                                   (lcd_data_o == 8'h03));
  assign lcd_rw_o  = 1'b0;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + (AW+1)'(1);
    else if (!push && pop) count_nxt = count - (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{rs: cmd.cmd_rs_i, data: cmd.cmd_data_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= S_IDLE;
      cnt             <= '0;
      lcd_en_o        <= 1'b0;
      lcd_rs_o        <= 1'b0;
      lcd_data_o      <= 8'h00;
      lcd_on_o        <= 1'b0;
      busy_o          <= 1'b0;
      cmd.cmd_ready_o <= 1'b0;
    end else begin
      lcd_on_o        <= 1'b1;
      cmd.cmd_ready_o <= (count_nxt != FULL_CNT);
      busy_o          <= (count_nxt != '0) || !go_idle;
      case (state)
        S_IDLE: begin
          if (pop) begin
            lcd_rs_o   <= head.rs;
            lcd_data_o <= head.data;
            state      <= S_SETUP;
            cnt        <= LD_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            state    <= S_PULSE;
            cnt      <= LD_EN;
            lcd_en_o <= 1'b1;
          end else cnt <= cnt - CW'(1);
        end
        S_PULSE: begin
          if (cnt == '0) begin
            state    <= S_HOLD;
            cnt      <= LD_HOLD;
            lcd_en_o <= 1'b0;
          end else cnt <= cnt - CW'(1);
        end
        S_HOLD: begin
          if (cnt == '0) begin
            state <= S_WAIT;
            cnt   <= is_clr ? LD_CLR : LD_WAIT;
          end else cnt <= cnt - CW'(1);
        end
        S_WAIT: begin
          if (cnt == '0) begin
            // Back-to-back commands skip IDLE to keep the cadence tight.
            if (pop) begin
              lcd_rs_o   <= head.rs;
              lcd_data_o <= head.data;
              state      <= S_SETUP;
              cnt        <= LD_SETUP;
            end else begin
              state <= S_IDLE;
              cnt   <= '0;
            end
          end else cnt <= cnt - CW'(1);
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_writer.sv
// Directed bench for lcd_writer with short timing parameters and hand-derived edge numbers.
module tb_lcd_writer;
  logic       clk = 1'b0;
  logic       rst;
  logic       busy, lcd_on, lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;
  int         cyc = 0;
  int         n_tests = 0, n_fail = 0;
  int         rise_q[$];
  logic [8:0] byte_q[$];
  logic       prev_en = 1'b0;
  logic       rw_seen = 1'b0;
  logic       saw_wait;

  lcd_writer_if cif();

  lcd_writer #(.FIFO_DEPTH(4), .SETUP_CYC(2), .EN_CYC(4), .HOLD_CYC(2),
               .WAIT_CYC(10), .CLR_WAIT_CYC(40)) dut (
    .clk_i(clk), .rst_i(rst), .cmd(cif), .busy_o(busy), .lcd_on_o(lcd_on),
    .lcd_en_o(lcd_en), .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw), .lcd_data_o(lcd_data));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Log every EN rising edge together with the byte on the bus.
  always @(negedge clk) begin
    if (lcd_en && !prev_en) begin
      rise_q.push_back(cyc);
      byte_q.push_back({lcd_rs, lcd_data});
    end
    if (lcd_rw !== 1'b0) rw_seen = 1'b1;
    prev_en = lcd_en;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Offer one command and return at the negedge after the accepting edge; valid stays high.
  task automatic push(input logic rs, input logic [7:0] d);
    int n = 0;
    cif.cmd_valid_i = 1'b1;
    cif.cmd_rs_i    = rs;
    cif.cmd_data_i  = d;
    while (!cif.cmd_ready_o && n < 500) begin
      saw_wait = 1'b1;
      tick();
      n++;
    end
    tick();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic clr_logs();
    rise_q.delete();
    byte_q.delete();
  endtask

  initial begin
    logic [31:0] en_vec, busy_vec;
    logic [8:0]  exp_b [6];
    rst = 1'b1;
    cif.cmd_valid_i = 1'b0;
    cif.cmd_rs_i    = 1'b0;
    cif.cmd_data_i  = 8'h00;
    saw_wait = 1'b0;
    repeat (3) tick();
    chk("rst_ready", {31'd0, cif.cmd_ready_o}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_on",    {31'd0, lcd_on}, 32'd0);
    chk("rst_pins",  {28'd0, lcd_en, lcd_rs, lcd_rw, 1'b0}, 32'd0);
    chk("rst_data",  {24'd0, lcd_data}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", {31'd0, cif.cmd_ready_o}, 32'd1);
    chk("post_rst_on",    {31'd0, lcd_on}, 32'd1);

    // Single data write: EN high after edges 3..6, busy through edge 18.
    en_vec = '0; busy_vec = '0;
    push(1'b1, 8'h41);
    cif.cmd_valid_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      en_vec[k]   = lcd_en;
      busy_vec[k] = busy;
      if (k == 1)  chk("single_bus_e1",  {23'd0, lcd_rs, lcd_data}, 32'h141);
      if (k == 19) chk("single_bus_e19", {23'd0, lcd_rs, lcd_data}, 32'h141);
    end
    chk("single_en_vec",   en_vec,   32'h0000_0078);
    chk("single_busy_vec", busy_vec, 32'h0007_FFFE);

    // Clear then data: 48-cycle spacing between EN rises.
    clr_logs();
    push(1'b0, 8'h01);
    push(1'b1, 8'h42);
    cif.cmd_valid_i = 1'b0;
    wait_idle("clr_idle", 400);
    chk("clr_rises", rise_q.size(), 2);
    if (rise_q.size() == 2) begin
      chk("clr_gap",  rise_q[1] - rise_q[0], 48);
      chk("clr_b0",   {23'd0, byte_q[0]}, 32'h001);
      chk("clr_b1",   {23'd0, byte_q[1]}, 32'h142);
    end
    chk("rw_low", {31'd0, rw_seen}, 32'd0);

    // Six pushes with valid held: backpressure, order, cadence.
    clr_logs();
    saw_wait = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_b[i] = {1'b1, 8'h60 + 8'(i)};
      push(1'b1, 8'h60 + 8'(i));
    end
    cif.cmd_valid_i = 1'b0;
    chk("fill_backpressure", {31'd0, saw_wait}, 32'd1);
    wait_idle("fill_idle", 600);
    chk("fill_count", rise_q.size(), 6);
    if (rise_q.size() == 6) begin
      for (int i = 0; i < 6; i++) chk($sformatf("fill_b%0d", i), {23'd0, byte_q[i]}, {23'd0, exp_b[i]});
      chk("fill_cadence", rise_q[5] - rise_q[0], 90);
    end

    // Push on the same edge as a pop while holding 3 entries.
    clr_logs();
    for (int i = 0; i < 6; i++) exp_b[i] = {1'b0, 8'h10 + 8'(i)};
    cif.cmd_valid_i = 1'b1; cif.cmd_rs_i = 1'b0;
    cif.cmd_data_i = 8'h10; tick();          // edge 0
    cif.cmd_data_i = 8'h11; tick();          // edge 1
    cif.cmd_data_i = 8'h12; tick();          // edge 2
    cif.cmd_data_i = 8'h13; tick();          // edge 3
    cif.cmd_valid_i = 1'b0;
    chk("wrap_ready_3", {31'd0, cif.cmd_ready_o}, 32'd1);
    repeat (15) tick();                      // now after edge 18
    cif.cmd_valid_i = 1'b1; cif.cmd_data_i = 8'h14;
    tick();                                  // edge 19: push + pop
    chk("wrap_ready_e19", {31'd0, cif.cmd_ready_o}, 32'd1);
    cif.cmd_data_i = 8'h15;
    tick();                                  // edge 20: fourth entry
    cif.cmd_valid_i = 1'b0;
    chk("wrap_ready_e20", {31'd0, cif.cmd_ready_o}, 32'd0);
    wait_idle("wrap_idle", 600);
    chk("wrap_count", rise_q.size(), 6);
    if (rise_q.size() == 6)
      for (int i = 0; i < 6; i++) chk($sformatf("wrap_b%0d", i), {23'd0, byte_q[i]}, {23'd0, exp_b[i]});

    // Reset during PULSE with two commands queued.
    push(1'b1, 8'h30);                       // edge 0
    push(1'b1, 8'h31);                       // edge 1
    push(1'b1, 8'h32);                       // edge 2
    cif.cmd_valid_i = 1'b0;
    tick();                                  // edge 3
    chk("prst_en", {31'd0, lcd_en}, 32'd1);
    rst = 1'b1;
    tick();                                  // edge 4 in reset
    chk("mrst_en",    {31'd0, lcd_en}, 32'd0);
    chk("mrst_busy",  {31'd0, busy}, 32'd0);
    chk("mrst_ready", {31'd0, cif.cmd_ready_o}, 32'd0);
    rst = 1'b0;
    clr_logs();
    repeat (60) tick();
    chk("mrst_no_pulse", rise_q.size(), 0);
    chk("mrst_idle",     {31'd0, busy}, 32'd0);
    push(1'b1, 8'h77);
    cif.cmd_valid_i = 1'b0;
    wait_idle("mrst_new_idle", 200);
    chk("mrst_new_count", rise_q.size(), 1);
    if (rise_q.size() == 1) chk("mrst_new_b", {23'd0, byte_q[0]}, 32'h177);

    // Wait selection: rs=0 0x03 is long, rs=1 0x01 and rs=0 0x04 are short.
    clr_logs();
    push(1'b0, 8'h03);
    push(1'b1, 8'h01);
    push(1'b0, 8'h04);
    push(1'b1, 8'h55);
    cif.cmd_valid_i = 1'b0;
    wait_idle("wsel_idle", 600);
    chk("wsel_count", rise_q.size(), 4);
    if (rise_q.size() == 4) begin
      chk("wsel_clr03",  rise_q[1] - rise_q[0], 48);
      chk("wsel_data01", rise_q[2] - rise_q[1], 18);
      chk("wsel_ins04",  rise_q[3] - rise_q[2], 18);
    end
    chk("rw_low_end", {31'd0, rw_seen}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
